pulse_sched: RTL and testbench
==============================

PULSE_SCHED -- requirements
Module: pulse_sched

Interface
REQ-001 Parameter NREQ, default 4, number of requesters; the value is fixed at 4 in this revision.
REQ-002 Parameter CW, default 2, width of the per-requester pulse-length field.
REQ-003 clk  input  1  single clock; all state changes occur on the rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-low: low forces reset immediately, independent of clk.
REQ-005 req  input  NREQ  level request, one bit per requester; a requester holds its bit until it sees its gnt bit.
REQ-006 len  input  NREQ*CW  per-requester length L; requester i uses bits [i*CW +: CW], sampled only at that requester's grant.
REQ-007 kill  input  1  synchronous abort of the pulse in progress.
REQ-008 gnt  output  NREQ  one-hot, single-cycle grant, registered.
REQ-009 pout  output  1  shared stretched-pulse output, registered.
REQ-010 owner  output  2  index of the current grant holder; valid while busy=1.
REQ-011 busy  output  1  high whenever the state is PULSE.
REQ-012 done  output  1  single-cycle pulse on the first cycle after any pulse ends.

Function
REQ-013 The block SHALL implement three states: IDLE, PULSE and GAP.
REQ-014 IDLE/GAP with any req bit set: the next edge SHALL select a winner W round-robin, enter PULSE, and set gnt=1<<W, pout=1, owner=W, cnt=0, Lq=len[W].
REQ-015 IDLE/GAP with req=0: GAP SHALL go to IDLE on the next edge; IDLE SHALL stay in IDLE.
REQ-016 Round-robin priority SHALL be ptr+1, ptr+2, ptr+3, ptr (mod 4), where ptr is the last winner; ptr SHALL update at every grant.
REQ-017 PULSE: pout SHALL stay 1 and cnt SHALL increment each edge; when cnt==Lq, the next edge SHALL enter GAP, so pout is high for exactly Lq+1 cycles (1..4 for CW=2).
REQ-018 kill=1 in PULSE SHALL force GAP on the next edge regardless of cnt; kill SHALL be ignored in IDLE and GAP.
REQ-019 kill=1 together with cnt==Lq SHALL behave as a normal end: GAP on the next edge, done=1.
REQ-020 GAP SHALL hold pout=0 and done=1 for exactly one cycle; back-to-back pulses SHALL therefore be separated by exactly one low cycle.
REQ-021 gnt SHALL be 0 except on the first PULSE cycle of each grant.
REQ-022 req bits that change during PULSE SHALL have no effect until the GAP cycle.
REQ-023 len changes after a grant SHALL NOT affect the pulse in progress, because Lq is latched at the grant.
REQ-024 cnt SHALL be CW bits wide and SHALL never wrap, since the exit occurs at cnt==Lq <= 2^CW-1.

Reset
REQ-025 rst low SHALL immediately force state=IDLE, pout=0, gnt=0, busy=0, done=0, owner=0, cnt=0, Lq=0, ptr=3.
REQ-026 Reset asserted mid-pulse SHALL drop pout within the same cycle, and no done pulse SHALL follow.
REQ-027 After rst deasserts, the first grant SHALL go to the lowest-index active requester.

Structure
REQ-028 Package pulse_sched_pkg SHALL hold the state encoding (IDLE=2'b00, PULSE=2'b01, GAP=2'b10), the NREQ constant and the CW default.
REQ-029 Sub-module rr_arb4 SHALL be combinational: inputs req[3:0] and ptr[1:0], outputs any and win[1:0]. All registers SHALL live in pulse_sched.

Verification
REQ-030 Single request: req=0001, len0=2 -> gnt=0001 for 1 cycle; pout high 3 cycles; done high 1 cycle; back to IDLE.
REQ-031 All requesting: req=1111 held, all len=0, each requester dropping its bit on its gnt -> grants in order 0,1,2,3; pout pattern 1,0,1,0,1,0,1,0.
REQ-032 Abort: len1=3, kill=1 on the 2nd PULSE cycle -> pout high exactly 2 cycles, done=1 on the next cycle, and the pending req2 is granted in that GAP cycle.
REQ-033 Mid-pulse reset: rst=0 on the 2nd cycle of a len=3 pulse -> pout, busy and gnt go to 0 within that cycle; no done; ptr=3; a subsequent req=1010 grants requester 1.
REQ-034 Length latch: len0 changes 3 -> 0 one cycle after gnt0 -> pout still high 4 cycles.
REQ-035 Simultaneous kill and last cycle: len=1, kill=1 on the 2nd PULSE cycle -> exactly 2 high cycles and a single done pulse.

Source files
------------

// File: rtl/pulse_sched_pkg.sv
// -----------------------------------------------------------------------------
// pulse_sched_pkg
//   Shared definitions for the pulse scheduler:
//     state_t     - FSM state encoding (IDLE / PULSE / GAP)
//     NREQ_FIXED  - number of requesters supported by this revision
//     CW_DEFAULT  - default width of each requester's pulse-length field
//     onehot_idx  - requester index -> one-hot grant vector
// -----------------------------------------------------------------------------
package pulse_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_PULSE = 2'b01,
        ST_GAP   = 2'b10
    } state_t;

    localparam int NREQ_FIXED = 4;
    localparam int CW_DEFAULT = 2;

    function automatic logic [NREQ_FIXED-1:0] onehot_idx(input logic [1:0] idx);
        return NREQ_FIXED'(1) << idx;
    endfunction

endpackage

// File: rtl/pulse_sched_rr_arb4.sv
// -----------------------------------------------------------------------------
// rr_arb4
//   Purely combinational 4-way round-robin arbiter. The requester after ptr
//   has highest priority and ptr itself the lowest.
//   Ports:
//     req [3:0]  request vector
//     ptr [1:0]  index of the previous winner
//     any        at least one request present
//     win [1:0]  selected requester (equals ptr when any=0)
// -----------------------------------------------------------------------------
module rr_arb4 (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic       any,
    output logic [1:0] win
);

    logic [1:0] cand;

    always_comb begin
        any  = 1'b0;
        win  = ptr;
        cand = ptr;
        // Scan ptr+1, ptr+2, ptr+3, ptr; 2-bit wrap gives the mod-4 rotation.
        for (int k = 1; k <= 4; k++) begin
            cand = ptr + 2'(k);
            if (!any && req[cand]) begin
                any = 1'b1;
                win = cand;
            end
        end
    end

endmodule

// File: rtl/pulse_sched.sv
// -----------------------------------------------------------------------------
// pulse_sched
//   Round-robin scheduler driving one shared stretched pulse. A granted
//   requester gets pout high for len+1 cycles, followed by a one-cycle gap.
//
//   state | meaning
//   ------+-----------------------------------------------------------------
//   IDLE  | no pulse, no request seen
//   PULSE | pout high, cnt counting up towards the latched length Lq
//   GAP   | single low cycle after a pulse, done=1; may grant immediately
//
//   Ports:
//     clk    clock, rising edge
//     rst    asynchronous active-low reset
//     req    level requests, one per requester
//     len    packed per-requester lengths, requester i at [i*CW +: CW]
//     kill   abort the pulse in progress (PULSE only)
//     gnt    one-hot single-cycle grant
//     pout   shared stretched pulse
//     owner  current grant holder, valid while busy
//     busy   state is PULSE
//     done   one cycle after any pulse ends
// -----------------------------------------------------------------------------
module pulse_sched
    import pulse_sched_pkg::*;
#(
    parameter int NREQ = NREQ_FIXED,
    parameter int CW   = CW_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*CW-1:0] len,
    input  logic               kill,
    output logic [NREQ-1:0]    gnt,
    output logic               pout,
    output logic [1:0]         owner,
    output logic               busy,
    output logic               done
);

    state_t          state_q;
    logic [NREQ-1:0] gnt_q;
    logic            pout_q;
    logic [1:0]      owner_q;
    logic            done_q;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   lq_q;
    logic [1:0]      ptr_q;

    logic            arb_any;
    logic [1:0]      arb_win;
    logic [CW-1:0]   len_arr [NREQ];
    logic [CW-1:0]   len_sel;
    logic [CW-1:0]   cnt_d;
    logic            pulse_end;

    rr_arb4 u_arb (
        .req (req),
        .ptr (ptr_q),
        .any (arb_any),
        .win (arb_win)
    );

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_len
        assign len_arr[gi] = len[gi*CW +: CW];
    end

    assign len_sel = len_arr[arb_win];
    assign cnt_d   = cnt_q + CW'(1);

    // A kill that lands on the final cycle is indistinguishable from a
    // normal end, so both fold into one exit condition.
    assign pulse_end = (cnt_q == lq_q) || kill;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            pout_q  <= 1'b0;
            owner_q <= 2'd0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            lq_q    <= '0;
            ptr_q   <= 2'd3;
        end else begin
            gnt_q  <= '0;
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_GAP: begin
                    if (arb_any) begin
                        state_q <= ST_PULSE;
                        gnt_q   <= NREQ'(onehot_idx(arb_win));
                        pout_q  <= 1'b1;
                        owner_q <= arb_win;
                        cnt_q   <= '0;
                        lq_q    <= len_sel;
                        ptr_q   <= arb_win;
                    end else begin
                        state_q <= ST_IDLE;
                        pout_q  <= 1'b0;
                    end
                end
                ST_PULSE: begin
                    if (pulse_end) begin
                        state_q <= ST_GAP;
                        pout_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q   <= cnt_d;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    pout_q  <= 1'b0;
                end
            endcase
        end
    end

    assign gnt   = gnt_q;
    assign pout  = pout_q;
    assign owner = owner_q;
    assign busy  = (state_q == ST_PULSE);
    assign done  = done_q;

endmodule

// File: tb/tb_pulse_sched.sv
module tb_pulse_sched;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [7:0] len;
    logic       kill;
    logic [3:0] gnt;
    logic       pout;
    logic [1:0] owner;
    logic       busy;
    logic       done;

    int n_cmp = 0;
    int n_bad = 0;

    pulse_sched #(.NREQ(4), .CW(2)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .len   (len),
        .kill  (kill),
        .gnt   (gnt),
        .pout  (pout),
        .owner (owner),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst_v;
        logic [3:0] req_v;
        logic [7:0] len_v;
        logic       kill_v;
        logic [3:0] gnt_e;
        logic       pout_e;
        logic [1:0] owner_e;
        logic       busy_e;
        logic       done_e;
    } vec_t;

    vec_t tbl [24];

    function automatic vec_t mk(input logic r, input logic [3:0] q, input logic [7:0] l,
                                input logic k, input logic [3:0] g, input logic p,
                                input logic [1:0] o, input logic b, input logic d);
        vec_t v;
        v.rst_v = r; v.req_v = q; v.len_v = l; v.kill_v = k;
        v.gnt_e = g; v.pout_e = p; v.owner_e = o; v.busy_e = b; v.done_e = d;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic expect_out(input string nm, input logic [3:0] g, input logic p,
                              input logic [1:0] o, input logic b, input logic d);
        chk({nm, ".gnt"},  32'(gnt),  32'(g));
        chk({nm, ".pout"}, 32'(pout), 32'(p));
        chk({nm, ".busy"}, 32'(busy), 32'(b));
        chk({nm, ".done"}, 32'(done), 32'(d));
        if (b) chk({nm, ".owner"}, 32'(owner), 32'(o));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0; req = '0; len = '0; kill = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    initial begin
        int n_hi;
        int n_done;
        rst = 1'b0; req = '0; len = '0; kill = 1'b0;

        //             rst req    len    kill gnt    p  own  b  d
        tbl[0]  = mk(0, 4'h0, 8'h00, 0, 4'h0, 0, 2'd0, 0, 0);
        tbl[1]  = mk(1, 4'h1, 8'h02, 0, 4'h1, 1, 2'd0, 1, 0);
        tbl[2]  = mk(1, 4'h0, 8'h02, 0, 4'h0, 1, 2'd0, 1, 0);
        tbl[3]  = mk(1, 4'h0, 8'h02, 0, 4'h0, 1, 2'd0, 1, 0);
        tbl[4]  = mk(1, 4'h0, 8'h02, 0, 4'h0, 0, 2'd0, 0, 1);
        tbl[5]  = mk(1, 4'h0, 8'h02, 0, 4'h0, 0, 2'd0, 0, 0);
        tbl[6]  = mk(0, 4'h0, 8'h00, 0, 4'h0, 0, 2'd0, 0, 0);
        tbl[7]  = mk(1, 4'hF, 8'h00, 0, 4'h1, 1, 2'd0, 1, 0);
        tbl[8]  = mk(1, 4'hE, 8'h00, 0, 4'h0, 0, 2'd0, 0, 1);
        tbl[9]  = mk(1, 4'hE, 8'h00, 0, 4'h2, 1, 2'd1, 1, 0);
        tbl[10] = mk(1, 4'hC, 8'h00, 0, 4'h0, 0, 2'd0, 0, 1);
        tbl[11] = mk(1, 4'hC, 8'h00, 0, 4'h4, 1, 2'd2, 1, 0);
        tbl[12] = mk(1, 4'h8, 8'h00, 0, 4'h0, 0, 2'd0, 0, 1);
        tbl[13] = mk(1, 4'h8, 8'h00, 0, 4'h8, 1, 2'd3, 1, 0);
        tbl[14] = mk(1, 4'h0, 8'h00, 0, 4'h0, 0, 2'd0, 0, 1);
        tbl[15] = mk(1, 4'h0, 8'h00, 0, 4'h0, 0, 2'd0, 0, 0);
        tbl[16] = mk(1, 4'h4, 8'h30, 0, 4'h4, 1, 2'd2, 1, 0);
        tbl[17] = mk(1, 4'h1, 8'h00, 0, 4'h0, 1, 2'd2, 1, 0);
        tbl[18] = mk(1, 4'h1, 8'h00, 0, 4'h0, 1, 2'd2, 1, 0);
        tbl[19] = mk(1, 4'h1, 8'h00, 0, 4'h0, 1, 2'd2, 1, 0);
        tbl[20] = mk(1, 4'h1, 8'h00, 0, 4'h0, 0, 2'd0, 0, 1);
        tbl[21] = mk(1, 4'h1, 8'h00, 0, 4'h1, 1, 2'd0, 1, 0);
        tbl[22] = mk(1, 4'h0, 8'h00, 0, 4'h0, 0, 2'd0, 0, 1);
        tbl[23] = mk(1, 4'h0, 8'h00, 0, 4'h0, 0, 2'd0, 0, 0);

        #2;
        for (int i = 0; i < 24; i++) begin
            rst = tbl[i].rst_v; req = tbl[i].req_v; len = tbl[i].len_v; kill = tbl[i].kill_v;
            tick();
            expect_out($sformatf("vec%0d", i), tbl[i].gnt_e, tbl[i].pout_e,
                       tbl[i].owner_e, tbl[i].busy_e, tbl[i].done_e);
        end

        // Abort: requester 1 with len=3 killed on its 2nd cycle, req2 waiting.
        do_reset();
        req = 4'b0010; len = 8'h0C; kill = 1'b0;
        tick(); expect_out("kill.gnt1",  4'b0010, 1, 2'd1, 1, 0);
        req = 4'b0100;
        tick(); expect_out("kill.cyc2",  4'b0000, 1, 2'd1, 1, 0);
        kill = 1'b1;
        tick(); expect_out("kill.gap",   4'b0000, 0, 2'd0, 0, 1);
        kill = 1'b0;
        tick(); expect_out("kill.gnt2",  4'b0100, 1, 2'd2, 1, 0);
        req = 4'b0000;
        tick(); expect_out("kill.gap2",  4'b0000, 0, 2'd0, 0, 1);
        tick(); expect_out("kill.idle",  4'b0000, 0, 2'd0, 0, 0);

        // Mid-pulse reset: requester 1 so a stale ptr would favour requester 3.
        do_reset();
        req = 4'b0010; len = 8'h0C;
        tick(); expect_out("mrst.gnt1", 4'b0010, 1, 2'd1, 1, 0);
        req = 4'b0000;
        tick(); expect_out("mrst.cyc2", 4'b0000, 1, 2'd1, 1, 0);
        rst = 1'b0;
        #1;
        expect_out("mrst.async", 4'b0000, 0, 2'd0, 0, 0);
        tick(); chk("mrst.held.done", 32'(done), 32'd0);
        rst = 1'b1;
        tick(); expect_out("mrst.after", 4'b0000, 0, 2'd0, 0, 0);
        req = 4'b1010; len = 8'h00;
        tick(); expect_out("mrst.regrant", 4'b0010, 1, 2'd1, 1, 0);
        req = 4'b0000;
        tick(); expect_out("mrst.gap", 4'b0000, 0, 2'd0, 0, 1);
        tick(); expect_out("mrst.idle", 4'b0000, 0, 2'd0, 0, 0);

        // Length latch: len0 drops 3 -> 0 right after the grant.
        do_reset();
        req = 4'b0001; len = 8'h03;
        tick(); expect_out("latch.gnt0", 4'b0001, 1, 2'd0, 1, 0);
        req = 4'b0000; len = 8'h00;
        n_hi = 1;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (pout) n_hi++;
            else break;
        end
        chk("latch.hi_cycles", 32'(n_hi), 32'd4);
        chk("latch.done", 32'(done), 32'd1);

        // Kill on the last cycle of a len=1 pulse, then kill ignored in GAP/IDLE.
        req = 4'b0001; len = 8'h01; kill = 1'b0;
        tick(); expect_out("simk.gnt0", 4'b0001, 1, 2'd0, 1, 0);
        req = 4'b0000;
        tick(); expect_out("simk.cyc2", 4'b0000, 1, 2'd0, 1, 0);
        kill = 1'b1;
        n_done = 0;
        tick(); expect_out("simk.gap", 4'b0000, 0, 2'd0, 0, 1);
        if (done) n_done++;
        tick(); expect_out("simk.idle", 4'b0000, 0, 2'd0, 0, 0);
        if (done) n_done++;
        chk("simk.done_count", 32'(n_done), 32'd1);
        req = 4'b0100; kill = 1'b1;
        tick(); expect_out("simk.idle_kill_grant", 4'b0100, 1, 2'd2, 1, 0);
        req = 4'b0000; kill = 1'b0;
        tick(); expect_out("simk.gap2", 4'b0000, 0, 2'd0, 0, 1);
        tick(); expect_out("simk.idle2", 4'b0000, 0, 2'd0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
